// File: rtl/adc_packetizer_64_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_packetizer_64_if
// Brief    : 64-bit AXI4-Stream bundle carried from the packetizer to its sink.
// Revision : 1.0 - initial release
// ============================================================================
interface adc_packetizer_64_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/adc_packetizer_64.sv
`default_nettype none
// ============================================================================
// Module   : adc_packetizer_64
// Brief    : Frames 4x16-bit ADC samples into fixed-length AXI-Stream packets
//            led by one header word, with a small FWFT FIFO and drop counter.
// Revision : 1.0 - initial release
// ============================================================================
module adc_packetizer_64 #(
    parameter int unsigned PKT_WIDTH  = 11,
    parameter int unsigned FIFO_AW    = 4,
    parameter logic [15:0] HDR_MARKER = 16'hADC0
) (
    input  wire logic                data_clk,
    input  wire logic                dma_rst,
    input  wire logic                dma_ena,
    input  wire logic                new_sample,
    input  wire logic [63:0]         adc_data,
    adc_packetizer_64_if.master      m_axis,
    output logic [15:0]              overflow_cnt,
    output logic [15:0]              pkt_seq,
    output logic                     busy
);

    localparam int unsigned          c_DEPTH    = 1 << FIFO_AW;
    localparam logic [PKT_WIDTH-1:0] c_LAST_CNT = {{(PKT_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [FIFO_AW:0]     c_ONE      = {{FIFO_AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [64:0]          r_mem [c_DEPTH];
    logic [FIFO_AW:0]     r_wr_ptr;
    logic [FIFO_AW:0]     r_rd_ptr;
    logic [PKT_WIDTH-1:0] r_cap_cnt;
    logic [15:0]          r_ovf_cnt;
    logic [15:0]          r_pkt_seq;
    logic [31:0]          r_sample_idx;

    logic                 w_empty;
    logic                 w_full;
    logic [FIFO_AW:0]     w_count;
    logic                 w_eligible;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;
    logic                 w_hdr_acc;
    logic                 w_more;
    logic [64:0]          w_head;
    logic                 w_tvalid;
    logic                 w_tlast;
    logic [63:0]          w_tdata;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                        (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_head     = r_mem[r_rd_ptr[FIFO_AW-1:0]];

    // An open packet keeps accepting samples even after enable drops.
    assign w_eligible = new_sample && (dma_ena || (r_cap_cnt != '0));
    assign w_push     = w_eligible && !w_full;
    assign w_drop     = w_eligible && w_full;

    assign w_pop      = (r_state == S_DATA) && !w_empty && m_axis.tready;
    assign w_hdr_acc  = (r_state == S_HDR) && m_axis.tready;
    // Occupancy after the current edge, including a concurrent push.
    assign w_more     = (w_count > c_ONE) || w_push;

    always_comb begin
        w_state_nxt = r_state;
        w_tvalid    = 1'b0;
        w_tlast     = 1'b0;
        w_tdata     = 64'd0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                w_tvalid = 1'b1;
                w_tdata  = {HDR_MARKER, r_pkt_seq, r_sample_idx};
                if (m_axis.tready) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_tvalid = !w_empty;
                w_tdata  = w_head[63:0];
                w_tlast  = w_head[64];
                if (w_pop && w_head[64]) begin
                    w_state_nxt = w_more ? S_HDR : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge data_clk) begin
        if (dma_rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_cap_cnt    <= '0;
            r_ovf_cnt    <= 16'd0;
            r_pkt_seq    <= 16'd0;
            r_sample_idx <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_cap_cnt <= (r_cap_cnt == c_LAST_CNT) ? '0 : r_cap_cnt + 1'b1;
            end
            if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + 1'b1;
                r_sample_idx <= r_sample_idx + 32'd1;
            end
            if (w_hdr_acc) begin
                r_pkt_seq <= r_pkt_seq + 16'd1;
            end
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge data_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= {(r_cap_cnt == c_LAST_CNT), adc_data};
        end
    end

    assign m_axis.tvalid = w_tvalid;
    assign m_axis.tdata  = w_tdata;
    assign m_axis.tlast  = w_tlast;
    assign m_axis.tkeep  = 8'hFF;

    assign overflow_cnt  = r_ovf_cnt;
    assign pkt_seq       = r_pkt_seq;
    assign busy          = (r_cap_cnt != '0) || (r_state != S_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_adc_packetizer_64.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_packetizer_64
// Brief    : Directed plus randomized bench for adc_packetizer_64 against a
//            queue-based packet model (PKT_WIDTH=3, FIFO_AW=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_packetizer_64;

    localparam int PW    = 3;
    localparam int AW    = 2;
    localparam int PKT   = 1 << PW;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        ns;
    logic [63:0] adc;
    logic [15:0] overflow_cnt;
    logic [15:0] pkt_seq;
    logic        busy;

    adc_packetizer_64_if axis ();

    adc_packetizer_64 #(
        .PKT_WIDTH  (PW),
        .FIFO_AW    (AW),
        .HDR_MARKER (16'hADC0)
    ) dut (
        .data_clk     (clk),
        .dma_rst      (rst),
        .dma_ena      (ena),
        .new_sample   (ns),
        .adc_data     (adc),
        .m_axis       (axis),
        .overflow_cnt (overflow_cnt),
        .pkt_seq      (pkt_seq),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Packet model: words queued with their tag, plus header bookkeeping.
    logic [64:0] mq[$];
    int          m_cap = 0;
    logic [15:0] m_ovf = 16'd0;
    logic [15:0] m_seq = 16'd0;
    logic [31:0] m_idx = 32'd0;
    bit          m_in_data = 1'b0;
    bit          m_live = 1'b0;
    int          lowrun = 0;

    logic [64:0] beats[$];
    int          beat_cyc[$];

    always @(negedge clk) begin
        logic hs;
        logic full;
        if (m_live) begin
            chk("overflow_cnt", 65'(overflow_cnt), 65'(m_ovf));
            chk("pkt_seq", 65'(pkt_seq), 65'(m_seq));
            chk("busy", 65'(busy), 65'((m_cap != 0) || (mq.size() != 0) || m_in_data));
            chk("tkeep", 65'(axis.tkeep), 65'h0FF);
            if (!m_in_data) begin
                if (axis.tvalid === 1'b1) begin
                    lowrun = 0;
                    chk("hdr_word", {axis.tlast, axis.tdata}, {1'b0, 16'hADC0, m_seq, m_idx});
                    chk("hdr_has_data", 65'(mq.size() != 0), 65'd1);
                end else if (mq.size() != 0) begin
                    lowrun++;
                    chk("hdr_due", 65'(lowrun <= 1), 65'd1);
                end else begin
                    lowrun = 0;
                end
            end else begin
                lowrun = 0;
                chk("data_tvalid", 65'(axis.tvalid), 65'(mq.size() != 0));
                if ((axis.tvalid === 1'b1) && (mq.size() != 0)) begin
                    chk("data_word", {axis.tlast, axis.tdata}, mq[0]);
                end
            end
        end

        hs = m_live && (axis.tvalid === 1'b1) && axis.tready;
        if (hs) begin
            beats.push_back({axis.tlast, axis.tdata});
            beat_cyc.push_back(cyc);
        end

        if (rst) begin
            mq.delete();
            m_cap = 0; m_ovf = 16'd0; m_seq = 16'd0; m_idx = 32'd0;
            m_in_data = 1'b0; lowrun = 0; m_live = 1'b1;
        end else if (m_live) begin
            full = (mq.size() == DEPTH);
            if (hs) begin
                if (!m_in_data) begin
                    m_seq++;
                    m_in_data = 1'b1;
                end else if (mq.size() != 0) begin
                    m_idx++;
                    if (mq[0][64]) m_in_data = 1'b0;
                    void'(mq.pop_front());
                end
            end
            if (ns && (ena || (m_cap != 0))) begin
                if (full) begin
                    if (m_ovf != 16'hFFFF) m_ovf++;
                end else begin
                    mq.push_back({(m_cap == PKT - 2), adc});
                    m_cap = (m_cap == PKT - 2) ? 0 : m_cap + 1;
                end
            end
        end
    end

    int s_cyc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe(input logic [63:0] d);
        ns = 1'b1; adc = d; s_cyc = cyc;
        tick();
        ns = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_beats(input int target, input int budget);
        int k = 0;
        while ((beats.size() < target) && (k < budget)) begin
            tick();
            k++;
        end
        chk("beat_budget", 65'(beats.size() >= target), 65'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int c1;
        rst = 1'b1; ena = 1'b0; ns = 1'b0; adc = 64'd0; axis.tready = 1'b0;
        idle(3);
        rst = 1'b0;
        chk("rst_tvalid", 65'(axis.tvalid), 65'd0);
        chk("rst_tlast", 65'(axis.tlast), 65'd0);
        chk("rst_tdata", 65'(axis.tdata), 65'd0);
        chk("rst_busy", 65'(busy), 65'd0);
        chk("rst_ovf", 65'(overflow_cnt), 65'd0);
        chk("rst_seq", 65'(pkt_seq), 65'd0);

        // One packet from spaced strobes 1..7.
        axis.tready = 1'b1; ena = 1'b1;
        b0 = beats.size(); c1 = 0;
        for (int i = 1; i <= 7; i++) begin
            strobe(64'(i));
            if (i == 1) c1 = s_cyc;
            idle(3);
        end
        wait_beats(b0 + 8, 50);
        chk("t1_hdr", beats[b0], {1'b0, 64'hADC0_0000_0000_0000});
        chk("t1_hdr_lat", 65'(beat_cyc[b0] - c1), 65'd2);
        chk("t1_d1_lat", 65'(beat_cyc[b0+1] - c1), 65'd3);
        for (int k = 1; k <= 7; k++) chk("t1_data", beats[b0+k], {(k == 7), 64'(k)});
        chk("t1_seq", 65'(pkt_seq), 65'd1);

        // Enable drops after the third strobe; packet still completes.
        b0 = beats.size();
        for (int i = 1; i <= 13; i++) begin
            ena = (i <= 3);
            strobe(64'(i));
            idle(3);
        end
        idle(5);
        wait_beats(b0 + 8, 50);
        chk("t2_hdr", beats[b0], {1'b0, 16'hADC0, 16'd1, 32'd7});
        for (int k = 1; k <= 7; k++) chk("t2_data", beats[b0+k], {(k == 7), 64'(k)});
        chk("t2_nbeats", 65'(beats.size() - b0), 65'd8);
        chk("t2_ovf", 65'(overflow_cnt), 65'd0);
        chk("t2_busy", 65'(busy), 65'd0);

        // Back-pressure overflow: 6 strobes into a 4-deep FIFO.
        axis.tready = 1'b0; ena = 1'b1;
        b0 = beats.size();
        for (int i = 1; i <= 6; i++) strobe(64'h100 + 64'(i));
        idle(2);
        chk("t3_ovf", 65'(overflow_cnt), 65'd2);
        chk("t3_hold_v", 65'(axis.tvalid), 65'd1);
        chk("t3_hold_d", 65'(axis.tdata), {1'b0, 16'hADC0, 16'd2, 32'd14});
        idle(3);
        chk("t3_hold_v2", 65'(axis.tvalid), 65'd1);
        chk("t3_hold_d2", 65'(axis.tdata), {1'b0, 16'hADC0, 16'd2, 32'd14});
        axis.tready = 1'b1;
        wait_beats(b0 + 5, 20);
        for (int k = 1; k <= 4; k++) chk("t3_data", beats[b0+k], {1'b0, 64'h100 + 64'(k)});
        for (int i = 7; i <= 9; i++) begin
            strobe(64'h100 + 64'(i));
            idle(1);
        end
        idle(10);

        // Continuous strobes: second header follows first tlast directly.
        do_reset();
        b0 = beats.size();
        for (int i = 0; i < 20; i++) strobe(64'h200 + 64'(i));
        for (int i = 0; (i < 20) && (m_cap != 0); i++) begin
            strobe(64'h300 + 64'(i));
            idle(1);
        end
        wait_beats(b0 + 16, 100);
        chk("t4_first", beats[b0+1], {1'b0, 64'h200});
        chk("t4_tlast", beats[b0+7], {1'b1, 64'h206});
        chk("t4_hdr2", beats[b0+8], {1'b0, 16'hADC0, 16'd1, 32'd7});
        chk("t4_hdr2_cyc", 65'(beat_cyc[b0+8] - beat_cyc[b0+7]), 65'd1);
        idle(10);

        // Pop and eligible strobe in the same cycle while full.
        do_reset();
        axis.tready = 1'b0;
        b0 = beats.size();
        for (int i = 1; i <= 4; i++) strobe(64'h400 + 64'(i));
        idle(1);
        axis.tready = 1'b1;
        tick();
        axis.tready = 1'b0;
        idle(1);
        axis.tready = 1'b1;
        strobe(64'hBAD);
        chk("t5_ovf", 65'(overflow_cnt), 65'd1);
        for (int i = 5; i <= 7; i++) begin
            strobe(64'h400 + 64'(i));
            idle(1);
        end
        wait_beats(b0 + 8, 30);
        chk("t5_hdr", beats[b0], {1'b0, 64'hADC0_0000_0000_0000});
        for (int k = 1; k <= 7; k++) chk("t5_data", beats[b0+k], {(k == 7), 64'h400 + 64'(k)});

        // Reset with three words queued.
        axis.tready = 1'b0;
        for (int i = 1; i <= 3; i++) strobe(64'h500 + 64'(i));
        idle(2);
        do_reset();
        chk("t6_tvalid", 65'(axis.tvalid), 65'd0);
        chk("t6_ovf", 65'(overflow_cnt), 65'd0);
        chk("t6_seq", 65'(pkt_seq), 65'd0);
        chk("t6_busy", 65'(busy), 65'd0);
        axis.tready = 1'b1;
        b0 = beats.size();
        strobe(64'h601);
        idle(3);
        chk("t6_hdr", beats[b0], {1'b0, 64'hADC0_0000_0000_0000});

        // Randomized traffic with varying back-pressure.
        for (int ph = 0; ph < 4; ph++) begin
            for (int n = 0; n < 1000; n++) begin
                ena = ($urandom_range(0, 9) != 0);
                ns = $urandom_range(0, 1);
                adc = {$urandom, $urandom};
                case (ph)
                    0:       axis.tready = 1'b1;
                    1:       axis.tready = ($urandom_range(0, 3) != 0);
                    2:       axis.tready = ($urandom_range(0, 3) == 0);
                    default: axis.tready = $urandom_range(0, 1);
                endcase
                tick();
            end
        end
        ns = 1'b0; ena = 1'b0; axis.tready = 1'b1;
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_packetizer_64.md
# adc_packetizer_64

- Frames raw multi-channel ADC samples into fixed-length 64-bit AXI4-Stream packets, each beginning with one header word.
- Runs entirely in the ADC data clock domain.
- Sits directly upstream of the clock-crossing AXI-Stream FIFO that feeds the XDMA C2H channel.
- Absorbs short back-pressure in a small internal FIFO and counts samples it has to drop.

## Interface
Parameters:
- PKT_WIDTH, 11: packet length is 2^PKT_WIDTH words (1 header + 2^PKT_WIDTH-1 data words); minimum 2.
- FIFO_AW, 4: internal FIFO depth is 2^FIFO_AW entries, each 65 bits (64 data + last tag).
- HDR_MARKER, 16'hADC0: constant placed in header bits [63:48].

Ports:
- data_clk  in  1  sole clock.
- dma_rst  in  1  synchronous reset, active-high.
- dma_ena  in  1  acquisition enable, level.
- new_sample  in  1  one-cycle strobe; adc_data is valid in this cycle.
- adc_data  in  64  four 16-bit channels {ch3,ch2,ch1,ch0}.
- m_axis_tdata  out  64  stream data.
- m_axis_tkeep  out  8  constant 8'hFF.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  last word of packet.
- overflow_cnt  out  16  dropped samples; saturates at 16'hFFFF.
- pkt_seq  out  16  number of headers accepted; wraps.
- busy  out  1  asserted while a packet is open or data is pending.

## Operation
Capture side:
- cap_cnt (PKT_WIDTH bits) counts data words captured in the current packet.
- A sample is eligible when new_sample && (dma_ena || cap_cnt != 0).
  - Once a packet has started, it always completes, even if dma_ena falls mid-packet.
  - A new packet starts only at a boundary (cap_cnt == 0) with dma_ena high.
- An eligible sample with FIFO not full is written together with tag = (cap_cnt == 2^PKT_WIDTH-2).
  - cap_cnt then increments; it wraps to 0 after the tagged word.
- An eligible sample with FIFO full is dropped:
  - overflow_cnt increments (saturating).
  - cap_cnt does not advance, so every packet keeps its full length.
- Fullness is evaluated before the edge: a pop in the same cycle does not rescue the write.

Output FSM, states IDLE, HDR, DATA:
- IDLE: tvalid=0, tdata=0, tlast=0. Moves to HDR when the FIFO is not empty.
- HDR: tvalid=1, tlast=0, tdata={HDR_MARKER, pkt_seq, sample_idx}.
  - On tready, pkt_seq increments and the FSM moves to DATA.
- DATA: tvalid=!empty, tdata=FIFO head data, tlast=head tag (first-word fall-through).
  - On tvalid&&tready, the head is popped and sample_idx (32-bit, wraps) increments.
  - Popping a tagged word moves to HDR if the FIFO is still non-empty after the pop, otherwise to IDLE.
- The header's sample_idx is the count of data words emitted before the header.
- busy = (cap_cnt != 0) || (state != IDLE) || !empty.
- The FSM never leaves HDR or DATA without a handshake. Unreachable state encodings go to IDLE.

## Timing
- Reset (dma_rst=1 at an edge) values:
  - state IDLE, FIFO empty, cap_cnt=0.
  - overflow_cnt=0, pkt_seq=0, sample_idx=0.
  - tvalid=0, tlast=0, tdata=0, busy=0.
- Reset mid-packet discards the FIFO contents and the partial packet, with no tlast emitted.
- Latency with tready held high:
  - Strobe in cycle c: the word is in the FIFO from c+1.
  - The FSM reaches HDR at c+2, so the header is valid in cycle c+2 (IDLE at c+1).
  - The first data word is valid in c+3.
- Between packets with a non-empty FIFO:
  - The next header follows the tlast beat in the next cycle.
  - Throughput is 1 word/cycle.
- AXI rules:
  - tvalid and tdata hold stable while tvalid && !tready.
  - tvalid never depends combinationally on tready.
- dma_ena sampled low at the cycle of a strobe with cap_cnt==0: the sample is ignored and not counted as overflow.

## Test plan
- PKT_WIDTH=3, dma_ena=1, tready=1, 7 strobes spaced 4 cycles with adc_data=1..7 -> one packet:
  - header 0xADC0_0000_0000_0000, then data 1..7, tlast only on 7.
  - pkt_seq=1.
- dma_ena dropped after the 3rd strobe, 10 further strobes -> only samples 4..7 are accepted (packet completes); the rest are ignored; overflow_cnt=0; busy falls after the tlast beat.
- tready=0 with FIFO_AW=2 and 6 back-to-back eligible strobes -> 4 stored, overflow_cnt=2, tvalid held with stable header; after tready=1, 4 data words emitted in order.
- Continuous strobes every cycle, tready=1, two packets -> second header {0xADC0, 16'd1, 32'd7} appears in the cycle directly after the first tlast beat.
- Simultaneous pop and eligible strobe while full -> sample dropped, overflow_cnt +1, popped word correct.
- dma_rst asserted mid-packet with 3 words queued -> next cycle tvalid=0, all counters 0; the next packet starts with header sample_idx=0.
